conv2d_stream_p: RTL and testbench

- Parametrised streaming 3x3 2D convolution engine; successor to the fixed 32x32, image-ROM-addressed convolution.
- Accepts a raster-order pixel stream over a valid/ready handshake, builds windows from two on-chip line buffers, and emits "valid" (unpadded) convolution results with backpressure.
- Adds runtime-loaded signed coefficients, output scaling, optional ReLU, saturation, and frame start/done control.
- Cascadable: the output of one instance can feed the input of the next, e.g. for a two-stage sharpen.

---
 rtl/conv2d_stream_p.sv | 170 +++++++++++++++++
 tb/tb_conv2d_stream_p.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/conv2d_stream_p.sv
// Streaming 3x3 convolution over a raster pixel stream with valid/ready on both sides.
// Two line buffers and a 3x3 window register feed a two-stage MAC pipeline, which holds whenever the output stalls.
module conv2d_stream_p #(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SHIFT  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [9*COEF_W-1:0]   coef,
  input  logic                  relu_en,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned AW = DATA_W + COEF_W + 4;
  localparam int unsigned EW = (AW > OUT_W) ? AW : OUT_W;
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic signed [EW-1:0] MAXV = EW'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [EW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                 state, state_d;
  logic                   done_d;
  logic [9*COEF_W-1:0]    coef_q;
  logic                   relu_q;
  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [DATA_W-1:0]      lb0 [IMG_W];
  logic [DATA_W-1:0]      lb1 [IMG_W];
  logic [DATA_W-1:0]      win [3][3];
  logic                   win_valid, win_last;
  logic signed [AW-1:0]   prod [9];
  logic signed [AW-1:0]   prod_d [9];
  logic                   s1_valid, s1_last;
  logic signed [AW-1:0]   acc, res;
  logic signed [EW-1:0]   res_e;
  logic [OUT_W-1:0]       sat;
  logic                   stall, accept, complete, last_pix;

  assign stall    = out_valid && !out_ready;
  assign in_ready = (state == RUN) && !stall;
  assign accept   = in_valid && in_ready;
  assign complete = (row >= RW'(2)) && (col >= CW'(2));
  assign last_pix = (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));
  assign busy     = (state != IDLE);

  // Frame control: next state and done pulse
  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    case (state)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && last_pix) state_d = FLUSH;
      FLUSH:   if (out_valid && out_ready && out_last) begin
                 state_d = IDLE;
                 done_d  = 1'b1;
               end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      done  <= done_d;
    end
  end

  // Frame configuration and raster position of the next pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coef_q <= '0;
      relu_q <= 1'b0;
      row    <= '0;
      col    <= '0;
    end else if (state == IDLE && start) begin
      coef_q <= coef;
      relu_q <= relu_en;
      row    <= '0;
      col    <= '0;
    end else if (accept) begin
      if (col == CW'(IMG_W-1)) begin
        col <= '0;
        row <= last_pix ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffers and window: column col of the two rows above, plus the new pixel
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col] <= lb1[col];
      lb1[col] <= in_data;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb0[col];
      win[1][2] <= lb1[col];
      win[2][2] <= in_data;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        prod_d[r*3+c] = AW'($signed({1'b0, win[r][c]}))
                      * AW'($signed(coef_q[(8-(r*3+c))*COEF_W +: COEF_W]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!stall && win_valid) begin
      for (int i = 0; i < 9; i++) prod[i] <= prod_d[i];
    end
  end

  // Sum, scale, optional ReLU, then clamp into the signed output range
  always_comb begin
    acc = '0;
    for (int i = 0; i < 9; i++) acc = acc + prod[i];
    res = acc >>> SHIFT;
    if (relu_q && res < 0) res = '0;
    res_e = EW'(res);
    if (res_e > MAXV)      sat = OUT_W'(MAXV);
    else if (res_e < MINV) sat = OUT_W'(MINV);
    else                   sat = OUT_W'(res_e);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      win_valid <= accept && complete;
      win_last  <= accept && last_pix;
      s1_valid  <= win_valid;
      s1_last   <= win_last;
      out_valid <= s1_valid;
      out_last  <= s1_last;
      if (s1_valid) out_data <= sat;
    end
  end

endmodule

// File: tb/tb_conv2d_stream_p.sv
// Directed bench for conv2d_stream_p on a 4x4 frame with 8-bit output.
// Table of whole-frame vectors, plus stall, latency and abort sequences.
module tb_conv2d_stream_p;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset, start, relu_en, in_valid, in_ready;
  logic [71:0] coef;
  logic [7:0]  in_data, out_data;
  logic        out_valid, out_ready, out_last, busy, done;

  always #5 clk = ~clk;

  conv2d_stream_p #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .COEF_W(8), .OUT_W(8), .SHIFT(0)) dut (
    .clk(clk), .reset(reset), .start(start), .coef(coef), .relu_en(relu_en),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  typedef struct {
    bit ramp; int val; int ctr; int oth; int idx; bit relu;
    int e0; int e1; int e2; int e3;
  } vec_t;

  vec_t tbl [11];
  int   checks = 0;
  int   errors = 0;
  int   res_q [$];
  bit   last_q [$];
  int   done_cnt, first_v, acc_cyc, done_cyc, last_hs, viol;
  bit   busy_after;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] kern(input int ctr, input int oth, input int idx);
    logic [71:0] k;
    for (int i = 0; i < 9; i++) k[(8-i)*8 +: 8] = (i == idx) ? 8'(ctr) : 8'(oth);
    return k;
  endfunction

  // Runs one frame; samples at negedge, drives for the following posedge
  task automatic run_frame(input bit ramp, input int val, input logic [71:0] k, input bit relu,
                           input bit gap, input bit toggle, input bit inj, input int abort_at);
    int pix = 0;
    bit injd = 0;
    bit was_stall = 0;
    logic [7:0] held = '0;
    res_q.delete(); last_q.delete();
    done_cnt = 0; first_v = -1; acc_cyc = -1; done_cyc = -1; last_hs = -1; viol = 0;
    @(negedge clk);
    coef = k; relu_en = relu; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (was_stall && out_data !== held) viol++;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (abort_at >= 0 && pix == abort_at) begin
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("abort busy", int'(busy), 0);
        check("abort out_valid", int'(out_valid), 0);
        check("abort in_ready", int'(in_ready), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          check("abort no done", int'(done), 0);
        end
        return;
      end
      out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      in_valid  = (pix < W*H) && !(gap && (cyc % 3 == 1));
      in_data   = ramp ? 8'(pix) : 8'(val);
      start     = inj && !injd && pix == 5;
      if (start) begin
        injd = 1'b1;
        coef = '0;
        relu_en = 1'b1;
      end
      #1;
      if (out_valid && !out_ready && in_ready) viol++;
      if (out_valid && out_ready) begin
        res_q.push_back(int'($signed(out_data)));
        last_q.push_back(out_last);
        last_hs = cyc;
      end
      if (in_valid && in_ready) begin
        if (pix == 10) acc_cyc = cyc;
        pix++;
      end
      was_stall = out_valid && !out_ready;
      held = out_data;
      @(negedge clk);
      start = 1'b0;
    end
    busy_after = busy;
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_frame(input string nm, input int e0, input int e1, input int e2, input int e3);
    int e [4];
    int nl = 0;
    e = '{e0, e1, e2, e3};
    check({nm, " count"}, res_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s r%0d", nm, i), (i < res_q.size()) ? res_q[i] : 9999, e[i]);
    foreach (last_q[i]) if (last_q[i]) nl++;
    check({nm, " last count"}, nl, 1);
    check({nm, " last pos"}, (last_q.size() > 0) ? int'(last_q[last_q.size()-1]) : 0, 1);
    check({nm, " done count"}, done_cnt, 1);
    check({nm, " busy after"}, int'(busy_after), 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; coef = '0; relu_en = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst in_ready", int'(in_ready), 0);
    check("rst out_valid", int'(out_valid), 0);
    check("rst out_last", int'(out_last), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst out_data", int'(out_data), 0);
    reset = 1'b1;

    tbl[0]  = '{1,   0,  1,  0, 4, 0,   5,   6,   9,  10};
    tbl[1]  = '{0,  10,  9, -1, 4, 0,  10,  10,  10,  10};
    tbl[2]  = '{0,  10,  0, -1, 4, 0, -80, -80, -80, -80};
    tbl[3]  = '{0,  10,  0, -1, 4, 1,   0,   0,   0,   0};
    tbl[4]  = '{0, 255,  9,  0, 4, 0, 127, 127, 127, 127};
    tbl[5]  = '{0, 255, -9,  0, 4, 0,-128,-128,-128,-128};
    tbl[6]  = '{1,   0,  1,  0, 0, 0,   0,   1,   4,   5};
    tbl[7]  = '{1,   0,  1,  0, 2, 0,   2,   3,   6,   7};
    tbl[8]  = '{1,   0,  2,  0, 8, 0,  20,  22,  28,  30};
    tbl[9]  = '{1,   0,  1,  0, 6, 0,   8,   9,  12,  13};
    tbl[10] = '{1,   0, -1,  0, 4, 0,  -5,  -6,  -9, -10};

    for (int i = 0; i < 11; i++) begin
      run_frame(tbl[i].ramp, tbl[i].val, kern(tbl[i].ctr, tbl[i].oth, tbl[i].idx),
                tbl[i].relu, 1'b0, 1'b0, 1'b0, -1);
      check_frame($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3);
      if (i == 0) begin
        check("latency", first_v - acc_cyc, 3);
        check("done delay", done_cyc - last_hs, 1);
      end
    end

    // Backpressure 1,0,0,1 with gapped input
    run_frame(1'b1, 0, kern(1, 0, 4), 1'b0, 1'b1, 1'b1, 1'b0, -1);
    check_frame("stall", 5, 6, 9, 10);
    check("stall hold/in_ready", viol, 0);

    // Abort after 7 pixels, then a clean frame with an ignored mid-frame start
    run_frame(1'b1, 0, kern(1, 0, 4), 1'b0, 1'b0, 1'b0, 1'b0, 7);
    run_frame(1'b1, 0, kern(1, 0, 4), 1'b0, 1'b0, 1'b0, 1'b1, -1);
    check_frame("post abort", 5, 6, 9, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
